instr_loader: RTL and testbench

Boot/reload sequencer for the instruction fetch stage. It streams a program image into the instruction cache through a valid/ready interface. While loading it holds fetch stalled and flushed. It then redirects the PC to BASE_ADDR and hands fetch control (pcSrc, branchPC, enables, flush) to the core pipeline. It sits between the host/debug stream, the core hazard unit and the fetch stage.

---
 rtl/instr_loader.sv | 117 +++++++++++
 tb/tb_instr_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot/reload sequencer: streams a program image into the instruction cache,
// holds fetch stalled/flushed meanwhile, then redirects the PC and hands fetch to the core.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] wordCount,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        core_pcSrc,
  input  logic [31:0] core_branchPC,
  input  logic        core_stall,
  input  logic        core_flush,
  output logic        w_en,
  output logic [31:0] w_addr,
  output logic [31:0] w_instr,
  output logic        en_pc,
  output logic        en_IF,
  output logic        pcSrc,
  output logic [31:0] branchPC,
  output logic        flush,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] REDIR0 = 3'd2;
  localparam logic [2:0] REDIR1 = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;

  logic [2:0]  state;
  logic [15:0] count;
  logic [15:0] index;
  logic        handshake;
  logic        last_word;
  logic        count_ok;

  assign in_ready  = (state == LOAD);
  assign handshake = in_valid && in_ready;
  assign last_word = (index == count - 16'd1);
  assign count_ok  = (wordCount != '0) && (32'(wordCount) <= MAX_WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      index   <= '0;
      w_en    <= 1'b0;
      w_addr  <= '0;
      w_instr <= '0;
    end else begin
      w_en <= handshake;
      if (handshake) begin
        // Word address wraps modulo 2^32 by design.
        w_addr  <= BASE_ADDR + {14'b0, index, 2'b00};
        w_instr <= in_data;
        index   <= index + 16'd1;
      end
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            if (count_ok) begin
              count <= wordCount;
              index <= '0;
              state <= LOAD;
            end else begin
              state <= ERR;
            end
          end
        end
        LOAD:    if (handshake && last_word) state <= REDIR0;
        REDIR0:  state <= REDIR1;
        REDIR1:  state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    en_pc    = 1'b0;
    en_IF    = 1'b0;
    pcSrc    = 1'b0;
    branchPC = '0;
    flush    = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      LOAD:   busy = 1'b1;
      REDIR0: begin
        busy     = 1'b1;
        en_pc    = 1'b1;
        pcSrc    = 1'b1;
        branchPC = BASE_ADDR;
      end
      REDIR1: busy = 1'b1;
      RUN: begin
        done     = 1'b1;
        pcSrc    = core_pcSrc;
        branchPC = core_branchPC;
        en_pc    = !core_stall;
        en_IF    = !core_stall;
        flush    = core_flush;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected cache writes are queued as words are
// offered; a monitor pops and compares each w_en pulse, including its cycle of arrival.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] wordCount = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        core_pcSrc = 1'b0;
  logic [31:0] core_branchPC = '0;
  logic        core_stall = 1'b0;
  logic        core_flush = 1'b0;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic        en_pc;
  logic        en_IF;
  logic        pcSrc;
  logic [31:0] branchPC;
  logic        flush;
  logic        busy;
  logic        done;
  logic        error;

  instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .wordCount(wordCount),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_pcSrc(core_pcSrc), .core_branchPC(core_branchPC),
    .core_stall(core_stall), .core_flush(core_flush),
    .w_en(w_en), .w_addr(w_addr), .w_instr(w_instr),
    .en_pc(en_pc), .en_IF(en_IF), .pcSrc(pcSrc), .branchPC(branchPC),
    .flush(flush), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;
  wr_t exp_q[$];

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected word.
  always @(negedge clk) begin
    wr_t e;
    if (w_en === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_w_en", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("w_addr", w_addr, e.addr);
        chk("w_instr", w_instr, e.data);
        chk("w_latency", cyc, e.cyc);
      end
    end
  end

  // Idle/error state outputs; starts and ends at posedge+1.
  task automatic idle_check(input logic exp_err);
    @(negedge clk);
    chk("idle_en_pc", en_pc, 0);
    chk("idle_en_IF", en_IF, 0);
    chk("idle_flush", flush, 1);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_pcSrc", pcSrc, 0);
    chk("idle_branchPC", branchPC, 0);
    chk("idle_w_en", w_en, 0);
    chk("idle_error", error, exp_err);
    @(posedge clk); #1;
  endtask

  task automatic bad_start(input int unsigned n);
    start = 1'b1;
    wordCount = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    idle_check(1'b1);
  endtask

  // mode 0: valid every cycle, 1: alternating 1-0-1..., 2: random gaps.
  task automatic load(input int unsigned n, input int unsigned mode);
    int unsigned k = 0;
    int unsigned t = 0;
    logic v;
    start = 1'b1;
    wordCount = 16'(n);
    @(posedge clk); #1;
    while (k < n && t < 4 * n + 20) begin
      case (mode)
        0: v = 1'b1;
        1: v = (t % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data = $urandom;
      // start and core inputs must be ignored while loading.
      start = 1'($urandom_range(0, 1));
      wordCount = 16'($urandom);
      core_pcSrc = 1'($urandom_range(0, 1));
      core_branchPC = $urandom;
      core_stall = 1'($urandom_range(0, 1));
      core_flush = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("load_in_ready", in_ready, 1);
      chk("load_busy", busy, 1);
      chk("load_done", done, 0);
      chk("load_error", error, 0);
      chk("load_en_pc", en_pc, 0);
      chk("load_en_IF", en_IF, 0);
      chk("load_flush", flush, 1);
      chk("load_pcSrc", pcSrc, 0);
      if (v) begin
        exp_q.push_back('{addr: BASE + 32'(4 * k), data: in_data, cyc: cyc + 1});
        k++;
      end
      t++;
      @(posedge clk); #1;
    end
    if (k < n) chk("load_timeout", k, n);
    in_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("redir0_en_pc", en_pc, 1);
    chk("redir0_en_IF", en_IF, 0);
    chk("redir0_pcSrc", pcSrc, 1);
    chk("redir0_branchPC", branchPC, BASE);
    chk("redir0_flush", flush, 1);
    chk("redir0_busy", busy, 1);
    chk("redir0_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("redir1_en_pc", en_pc, 0);
    chk("redir1_en_IF", en_IF, 0);
    chk("redir1_flush", flush, 1);
    chk("redir1_busy", busy, 1);
    chk("redir1_done", done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("run_error", error, 0);
    chk("run_in_ready", in_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_check(input int unsigned cycles);
    core_stall = 1'b1;
    core_pcSrc = 1'b1;
    core_branchPC = 32'h40;
    core_flush = 1'b1;
    for (int i = 0; i <= int'(cycles); i++) begin
      if (i > 0) begin
        core_stall = 1'($urandom_range(0, 1));
        core_pcSrc = 1'($urandom_range(0, 1));
        core_branchPC = $urandom;
        core_flush = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("pt_en_pc", en_pc, !core_stall);
      chk("pt_en_IF", en_IF, !core_stall);
      chk("pt_pcSrc", pcSrc, core_pcSrc);
      chk("pt_branchPC", branchPC, core_branchPC);
      chk("pt_flush", flush, core_flush);
      chk("pt_done", done, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_w_instr", w_instr, 0);
    @(posedge clk); #1;
    repeat (3) idle_check(1'b0);

    load(4, 0);
    run_check(8);
    load(3, 1);

    bad_start(0);
    bad_start(1025);
    bad_start($urandom_range(1025, 65535));
    load(1, 0);
    run_check(8);

    load(1024, 0);
    for (int i = 0; i < 6; i++) load($urandom_range(1, 40), 2);

    // Reset after two words of an eight-word image.
    start = 1'b1;
    wordCount = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      @(negedge clk);
      exp_q.push_back('{addr: BASE + 32'(4 * i), data: in_data, cyc: cyc + 1});
      @(posedge clk); #1;
    end
    rst = 1'b1;
    in_data = $urandom;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) idle_check(1'b0);
    in_valid = 1'b0;

    load(3, 0);
    load(5, 2);
    run_check(4);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
